// File: rtl/kw_demux_n_onehot_reg.sv
// Registered one-hot demultiplexer: one input stream fanned out to N
// valid/ready channels through a single-entry output register.
module kw_demux_n_onehot_reg #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [N-1:0]         i_sel_onehot,
    input  logic [WIDTH-1:0]     i_data,
    output logic [N-1:0]         o_valid,
    input  logic [N-1:0]         i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [N-1:0] SEL_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic [N-1:0]         sel_q;
    logic [WIDTH-1:0]     data_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic full;
    logic out_fire;
    logic in_fire;
    logic legal;
    logic load;
    logic drop;
    logic cnt_max;

    // x & (x-1) clears the lowest set bit; zero result plus nonzero x means one-hot
    assign legal = (i_sel_onehot != '0) &&
                   ((i_sel_onehot & (i_sel_onehot - SEL_ONE)) == '0);

    assign full     = (state_q == FULL);
    assign o_valid  = {N{full}} & sel_q;
    assign o_data   = data_q;
    assign o_err    = err_q;
    assign o_drop_count = cnt_q;

    assign out_fire = |(o_valid & i_ready);
    assign o_ready  = !full || out_fire;
    assign in_fire  = i_valid && o_ready;
    assign load     = in_fire && legal;
    assign drop     = in_fire && !legal;
    assign cnt_max  = (cnt_q == '1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_fire && !load) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload only moves on a legal accept, so drops never touch a held beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_q  <= '0;
            data_q <= '0;
        end else if (load) begin
            sel_q  <= i_sel_onehot;
            data_q <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= drop;
            if (drop && !cnt_max) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kw_demux_n_onehot_reg.sv
// Bench for kw_demux_n_onehot_reg: directed cases with literal expectations
// plus a randomised run against a queue-based reference model.
module tb_kw_demux_n_onehot_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_sel_onehot;
    logic [15:0] i_data;
    logic [3:0]  o_valid;
    logic [3:0]  i_ready;
    logic [15:0] o_data;
    logic        o_err;
    logic [7:0]  o_drop_count;

    kw_demux_n_onehot_reg #(.N(4), .WIDTH(16), .CNT_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_sel_onehot (i_sel_onehot),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_err        (o_err),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    dut_deliv = 0;
    int    legal_acc = 0;
    int    exp_cnt = 0;
    bit    exp_err = 0;
    bit    last_acc = 0;
    bit    cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit is_onehot(input logic [3:0] s);
        return $countones(s) == 1;
    endfunction

    // Reference: a FIFO of pending beats; the head leaves when its sink is ready
    task automatic model_update();
        bit deliver;
        bit accept;
        bit ok;
        deliver = 0;
        if (q.size() > 0) deliver = (q[0].sel & i_ready) != 0;
        accept = i_valid && (q.size() == 0 || deliver);
        ok = is_onehot(i_sel_onehot);
        if (deliver) void'(q.pop_front());
        if (accept && ok) begin
            q.push_back('{i_sel_onehot, i_data});
            legal_acc++;
        end
        exp_err = accept && !ok;
        if (exp_err && exp_cnt < 255) exp_cnt++;
        last_acc = accept;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            logic [3:0] ev;
            bit er;
            ev = 4'b0000;
            er = 1'b1;
            if (q.size() > 0) begin
                ev = q[0].sel;
                er = (q[0].sel & i_ready) != 0;
                chk("o_data", {16'h0, o_data}, {16'h0, q[0].data});
            end
            chk("o_valid", {28'h0, o_valid}, {28'h0, ev});
            chk("o_ready", {31'h0, o_ready}, {31'h0, er});
            chk("o_err", {31'h0, o_err}, {31'h0, exp_err});
            chk("o_drop_count", {24'h0, o_drop_count}, exp_cnt);
            if ((o_valid & i_ready) != 0) dut_deliv++;
        end
    end

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic [15:0] d, input logic [3:0] r);
        @(posedge clk);
        if (!rst) model_update();
        #1;
        i_valid      = v;
        i_sel_onehot = s;
        i_data       = d;
        i_ready      = r;
    endtask

    task automatic model_clear();
        legal_acc -= q.size();
        q.delete();
        exp_err = 0;
        exp_cnt = 0;
        last_acc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] s;
        logic [15:0] d;
        logic v;
        int d0;
        rst = 1'b1;
        i_valid = 0;
        i_sel_onehot = 0;
        i_data = 0;
        i_ready = 4'b1111;
        do_reset();
        cmp_en = 1;

        @(negedge clk);
        #1;
        chk("rst_o_valid", {28'h0, o_valid}, 0);
        chk("rst_o_data", {16'h0, o_data}, 0);
        chk("rst_o_err", {31'h0, o_err}, 0);
        chk("rst_drop", {24'h0, o_drop_count}, 0);
        chk("rst_o_ready", {31'h0, o_ready}, 1);

        // single beat, 1-cycle latency
        drive(1, 4'b0100, 16'hA5A5, 4'b1111);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t1_valid", {28'h0, o_valid}, 32'h4);
        chk("t1_data", {16'h0, o_data}, 32'hA5A5);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t1_valid_after", {28'h0, o_valid}, 0);

        // back-to-back beats to different channels
        drive(1, 4'b0001, 16'h0001, 4'b1111);
        drive(1, 4'b0010, 16'h0002, 4'b1111);
        @(negedge clk);
        #1;
        chk("t2_v1", {28'h0, o_valid}, 32'h1);
        chk("t2_rdy1", {31'h0, o_ready}, 1);
        drive(1, 4'b1000, 16'h0003, 4'b1111);
        @(negedge clk);
        #1;
        chk("t2_v2", {28'h0, o_valid}, 32'h2);
        chk("t2_rdy2", {31'h0, o_ready}, 1);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t2_v3", {28'h0, o_valid}, 32'h8);
        chk("t2_d3", {16'h0, o_data}, 32'h3);

        // selected sink stalls while others are ready
        drive(1, 4'b0010, 16'h1234, 4'b1101);
        drive(0, 4'b0000, 16'h0000, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t3_valid", {28'h0, o_valid}, 32'h2);
            chk("t3_data", {16'h0, o_data}, 32'h1234);
            chk("t3_ready", {31'h0, o_ready}, 0);
            drive(0, 4'b0000, 16'h0000, 4'b1101);
        end
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        #1;
        chk("t3_ready_comb", {31'h0, o_ready}, 1);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t3_drained", {28'h0, o_valid}, 0);

        // illegal selects are dropped and counted
        do_reset();
        drive(1, 4'b0000, 16'h1111, 4'b1111);
        drive(1, 4'b0110, 16'h2222, 4'b1111);
        @(negedge clk);
        #1;
        chk("t4_err1", {31'h0, o_err}, 1);
        chk("t4_cnt1", {24'h0, o_drop_count}, 1);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t4_err2", {31'h0, o_err}, 1);
        chk("t4_cnt2", {24'h0, o_drop_count}, 2);
        chk("t4_valid", {28'h0, o_valid}, 0);
        drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t4_err_end", {31'h0, o_err}, 0);

        // async reset while a beat is stalled
        drive(1, 4'b0001, 16'hBEEF, 4'b0000);
        drive(0, 4'b0000, 16'h0000, 4'b0000);
        @(negedge clk);
        #1;
        chk("t5_held", {28'h0, o_valid}, 32'h1);
        chk("t5_cnt_pre", {24'h0, o_drop_count}, 2);
        rst = 1'b1;
        model_clear();
        #1;
        chk("t5_valid_rst", {28'h0, o_valid}, 0);
        chk("t5_cnt_rst", {24'h0, o_drop_count}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_ready = 4'b1111;
        d0 = dut_deliv;
        repeat (3) drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("t5_no_deliv", dut_deliv, d0);
        chk("t5_valid_after", {28'h0, o_valid}, 0);

        // randomised traffic
        v = 0;
        s = 0;
        d = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!(i_valid && !last_acc)) begin
                v = ($urandom % 4) != 0;
                if (($urandom % 4) == 0) s = 4'($urandom);
                else s = 4'b0001 << ($urandom % 4);
                d = 16'($urandom);
            end
            drive(v, s, d, {($urandom % 3) != 0, ($urandom % 3) != 0,
                            ($urandom % 3) != 0, ($urandom % 3) != 0});
        end
        repeat (4) drive(0, 4'b0000, 16'h0000, 4'b1111);
        @(negedge clk);
        #1;
        chk("rand_deliv_total", dut_deliv, legal_acc);
        chk("rand_drop_sat", {24'h0, o_drop_count}, exp_cnt);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
